// File: rtl/bht_sat_predictor.sv
// Branch history table of 2-bit saturating counters with a registered prediction and a multi-cycle valid sweep.
// Optional macro BHT_BYPASS_EN forwards a same-cycle, same-index update into the prediction register.
module bht_sat_predictor #(
    parameter int BHT_ENTRIES = 128,
    parameter int VLEN        = 64,
    parameter int SWEEP_WIDTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] vpc_i,
    input  logic            bht_update_valid_i,
    input  logic [VLEN-1:0] bht_update_pc_i,
    input  logic            bht_update_taken_i,
    output logic            bht_pred_valid_o,
    output logic            bht_pred_taken_o,
    output logic            busy_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [IDX_W-1:0] PTR_STEP = IDX_W'(SWEEP_WIDTH);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(BHT_ENTRIES - SWEEP_WIDTH);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             valid_q [BHT_ENTRIES];
    logic [1:0]       cnt_q   [BHT_ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic             lk_en, upd_en;
    logic             upd_old_valid;
    logic [1:0]       upd_old_cnt, upd_new_cnt;
    logic             pred_valid_q, pred_taken_q;

    // Half-word aligned index; PC bit 0 and the untagged upper bits do not participate.
    assign lk_idx  = vpc_i[IDX_W:1];
    assign upd_idx = bht_update_pc_i[IDX_W:1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0],
                              bht_update_pc_i[VLEN-1:IDX_W+1], bht_update_pc_i[0]};

    // A flush in the same cycle wins over both lookup and update.
    assign lk_en  = (state_q == ST_IDLE) && lookup_valid_i && !flush_bp_i;
    assign upd_en = (state_q == ST_IDLE) && bht_update_valid_i && !debug_mode_i && !flush_bp_i;

    assign upd_old_valid = valid_q[upd_idx];
    assign upd_old_cnt   = cnt_q[upd_idx];

    always_comb begin
        upd_new_cnt = upd_old_cnt;
        if (!upd_old_valid) begin
            upd_new_cnt = bht_update_taken_i ? 2'b10 : 2'b01;
        end else if (bht_update_taken_i) begin
            if (upd_old_cnt != 2'b11) upd_new_cnt = upd_old_cnt + 2'b01;
        end else begin
            if (upd_old_cnt != 2'b00) upd_new_cnt = upd_old_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_SWEEP: begin
                if (flush_bp_i) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_STEP;
                end
            end
            default: begin
                if (flush_bp_i) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_SWEEP);
    end

    // Counters keep their value across sweeps; only the valid bits are cleared.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_SWEEP) begin
                for (int i = 0; i < SWEEP_WIDTH; i++) begin
                    valid_q[ptr_q + IDX_W'(i)] <= 1'b0;
                end
            end else if (upd_en) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (upd_en) begin
            cnt_q[upd_idx] <= upd_new_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
`ifdef BHT_BYPASS_EN
            if (lk_en && upd_en && (lk_idx == upd_idx)) begin
                pred_valid_q <= 1'b1;
                pred_taken_q <= upd_new_cnt[1];
            end else begin
                pred_valid_q <= lk_en && valid_q[lk_idx];
                pred_taken_q <= lk_en && valid_q[lk_idx] && cnt_q[lk_idx][1];
            end
`else
            pred_valid_q <= lk_en && valid_q[lk_idx];
            pred_taken_q <= lk_en && valid_q[lk_idx] && cnt_q[lk_idx][1];
`endif
        end
    end

    assign bht_pred_valid_o = pred_valid_q;
    assign bht_pred_taken_o = pred_taken_q;

endmodule

// File: doc/bht_sat_predictor.md
# bht_sat_predictor

Branch history table for the frontend. It holds `BHT_ENTRIES` 2-bit saturating counters, indexed by the half-word-aligned fetch PC, so compressed instructions get their own entries. It returns a registered taken/not-taken prediction one cycle after a lookup and trains the counters from resolved-branch updates sent back by the execute stage. It sits between the instruction-fetch address stage and the branch-prediction mux. On reset and on predictor flush it clears itself with a multi-cycle sweep.

## Interface
Parameters:
- `BHT_ENTRIES`, default 128: number of counters; must be a power of two and at least `SWEEP_WIDTH`.
- `VLEN`, default 64: virtual address width.
- `SWEEP_WIDTH`, default 8: entries invalidated per sweep cycle; must be a power of two.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  synchronous active-high reset.
- `flush_bp_i`  in  1  invalidate all entries (starts a sweep).
- `debug_mode_i`  in  1  core in debug mode; updates are suppressed.
- `lookup_valid_i`  in  1  lookup request this cycle.
- `vpc_i`  in  VLEN  fetch PC to look up.
- `bht_update_valid_i`  in  1  resolved conditional branch.
- `bht_update_pc_i`  in  VLEN  PC of the resolved branch.
- `bht_update_taken_i`  in  1  branch outcome.
- `bht_pred_valid_o`  out  1  prediction valid (registered).
- `bht_pred_taken_o`  out  1  predicted taken (registered).
- `busy_o`  out  1  sweep in progress.

## Operation
- IDX_W = log2(`BHT_ENTRIES`). Index = `pc[IDX_W:1]`; bit 0 is ignored and upper bits are not tagged, so aliasing is accepted.
- Per-entry state: a valid bit and a 2-bit counter (00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken).
- FSM states:
  - SWEEP (entered on reset):
    - Clears valid bits `[ptr +: SWEEP_WIDTH]` each cycle; ptr starts at 0 and steps by `SWEEP_WIDTH`.
    - Moves to IDLE after the cycle that clears the last group, i.e. `BHT_ENTRIES/SWEEP_WIDTH` cycles.
    - `busy_o`=1. Lookups return invalid and updates are dropped.
  - IDLE:
    - `flush_bp_i`=1 moves to SWEEP with ptr=0.
    - `flush_bp_i` during SWEEP restarts ptr at 0.
- Lookup (IDLE, `lookup_valid_i`=1):
  - Next cycle `bht_pred_valid_o` = entry valid and `bht_pred_taken_o` = counter[1].
  - Otherwise, next cycle both outputs are 0.
- Update (IDLE, `bht_update_valid_i`=1, `debug_mode_i`=0):
  - Invalid entry: set valid; counter = 10 if taken, else 01.
  - Valid entry: counter +1 if taken, saturating at 11; counter −1 if not taken, saturating at 00.
- `flush_bp_i` and an update in the same IDLE cycle: the flush wins and the update is dropped.
- A lookup and an update to the same index in the same cycle: the read returns the pre-update state (read-before-write), unless the bypass feature below is compiled in.
- Counter values are not cleared by the sweep; only the valid bits are.

## Timing
- Lookup latency is 1 cycle. Outputs are registered, with no combinational path from inputs to outputs.
- An update is visible to a lookup issued in the following cycle.
- After `rst_i` is deasserted, `busy_o` stays 1 for `BHT_ENTRIES/SWEEP_WIDTH` cycles (16 by default). The first valid prediction is possible on the cycle after `busy_o` falls plus 1.
- Reset values: `bht_pred_valid_o`=0, `bht_pred_taken_o`=0, `busy_o`=1, state=SWEEP, ptr=0.
- While `rst_i` is held, the state is held at SWEEP with ptr=0. Reset asserted mid-sweep or mid-operation restarts the full sweep.
- `flush_bp_i` in cycle N: `busy_o`=1 from N+1. A lookup issued in cycle N returns invalid in N+1.

## Configuration
- `BHT_BYPASS_EN` defined: a same-cycle lookup and update to the same index forwards the post-update valid bit and counter into the prediction register.
- `BHT_BYPASS_EN` undefined: read-before-write as in Operation. The forwarding mux is not instantiated.

## Test plan
- Reset: deassert `rst_i` -> `busy_o`=1 for exactly 16 cycles. A lookup at pc 0x8000_0000 afterwards returns valid=0, taken=0.
- Training: 3 taken updates at pc 0x8000_0010 -> counter goes 10, 11, 11 (saturated). Lookup returns valid=1, taken=1. Then 2 not-taken updates -> counter 01, lookup returns taken=0.
- Aliasing and RVC: update taken at 0x8000_0002, then lookup 0x8000_0000 -> valid=0. Lookup 0x8000_0102 (same index, 0x102 = 258 ≡ 2 mod 256) -> valid=1, taken=1.
- Flush mid-sweep: assert `flush_bp_i` at sweep cycle 10 -> `busy_o` stays high for 16 further cycles, and all prior entries read invalid afterwards.
- Debug and collision: an update with `debug_mode_i`=1 leaves the entry invalid. A flush plus update in the same cycle leaves the entry invalid after the sweep.
- Same-cycle lookup and update at 0x8000_0040 on an invalid entry, taken=1 -> prediction valid=0 without `BHT_BYPASS_EN`; valid=1, taken=1 with it.
